// File: rtl/udp_arb_pkg.sv
// Shared constants and types for the MAC TX arbiter.
package udp_arb_pkg;

  // Requester indices on the req/gnt/data vectors
  localparam int REQ_ARP  = 0;
  localparam int REQ_IP   = 1;
  localparam int REQ_ICMP = 2;

  // Default watchdog limit in cycles without an accepted beat
  localparam int TIMEOUT_CYC_DEFAULT = 4096;

  // Arbiter state: waiting for a request, or streaming one owner's frame
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, cyclic.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] k;

  // Scan from the pointer upward with wrap; the first hit wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter sharing the MAC TX beat stream between frame builders.
// Handshake: a beat moves when mac_wld_o & mac_ready_i are both high on a rising
// edge; the owner must keep data/be/tlast stable while valid is high and ready low.
// The grant is held for the whole frame and released after the tlast beat moves,
// or by the watchdog if the owner stops making progress.
module mac_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 32,
  parameter int BE_W        = DATA_W / 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                      clk_user_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic [NUM_REQ-1:0]        data_wld_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic [NUM_REQ*BE_W-1:0]   data_be_i,
  input  logic [NUM_REQ-1:0]        data_tlast_i,
  output logic [NUM_REQ-1:0]        data_ready_o,
  output logic                      mac_wld_o,
  output logic [DATA_W-1:0]         mac_data_o,
  output logic [BE_W-1:0]           mac_be_o,
  output logic                      mac_tlast_o,
  input  logic                      mac_ready_i,
  output logic                      abort_o,
  output arb_state_e                state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;
  logic [IDX_W-1:0]   ptr_adv;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign accept  = mac_wld_o & mac_ready_i;
  // Pointer moves just past the current owner so it goes last next round
  assign ptr_adv = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

  // State register; reset drops the grant so all muxed outputs read 0 at once
  always_ff @(posedge clk_user_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Next-state: grant in IDLE, release on tlast acceptance or watchdog expiry
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          cnt_d = '0;
          if (mac_tlast_o) begin
            gnt_d   = '0;
            ptr_d   = ptr_adv;
            state_d = ST_IDLE;
          end
        end else if (WD_EN && (cnt_q == CNT_MAX)) begin
          // Owner stalled too long: drop it mid-frame, MAC discards the fragment
          abort_d = 1'b1;
          gnt_d   = '0;
          ptr_d   = ptr_adv;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output mux: only the granted requester reaches the MAC and sees ready
  always_comb begin
    mac_wld_o    = 1'b0;
    mac_data_o   = '0;
    mac_be_o     = '0;
    mac_tlast_o  = 1'b0;
    data_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        mac_wld_o       = mac_wld_o   | data_wld_i[k];
        mac_data_o      = mac_data_o  | data_i[k*DATA_W +: DATA_W];
        mac_be_o        = mac_be_o    | data_be_i[k*BE_W +: BE_W];
        mac_tlast_o     = mac_tlast_o | data_tlast_i[k];
        data_ready_o[k] = mac_ready_i;
      end
    end
  end

  assign gnt_o   = gnt_q;
  assign abort_o = abort_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter with a beat scoreboard on the MAC side.
module tb_mac_tx_arbiter;
  import udp_arb_pkg::*;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int BW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    wld = '0;
  logic [NR*DW-1:0] data = '0;
  logic [NR*BW-1:0] be = '0;
  logic [NR-1:0]    tlast = '0;
  logic             mac_ready = 1'b1;

  logic [NR-1:0] gnt_o, data_ready_o;
  logic          mac_wld_o, mac_tlast_o, abort_o;
  logic [DW-1:0] mac_data_o;
  logic [BW-1:0] mac_be_o;
  arb_state_e    state_o;

  mac_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .BE_W(BW), .TIMEOUT_CYC(16)
  ) dut (
    .clk_user_i   (clk),
    .reset_i      (rst),
    .req_i        (req),
    .gnt_o        (gnt_o),
    .data_wld_i   (wld),
    .data_i       (data),
    .data_be_i    (be),
    .data_tlast_i (tlast),
    .data_ready_o (data_ready_o),
    .mac_wld_o    (mac_wld_o),
    .mac_data_o   (mac_data_o),
    .mac_be_o     (mac_be_o),
    .mac_tlast_o  (mac_tlast_o),
    .mac_ready_i  (mac_ready),
    .abort_o      (abort_o),
    .state_o      (state_o)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int n_beats = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted MAC beat must match the next expected beat
  always @(negedge clk) begin
    if (!rst && mac_wld_o && mac_ready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat_q", 64'(exp_q.size()), 64'd1);
      end else begin
        check("mac_beat", 64'({mac_tlast_o, mac_be_o, mac_data_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] pat(input int k, input int b);
    return {8'hA0, 8'(k), 16'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int k, input int b, input int n, input logic [3:0] last_be);
    wld[k]            = 1'b1;
    data[k*DW +: DW]  = pat(k, b);
    be[k*BW +: BW]    = (b == n - 1) ? last_be : 4'hF;
    tlast[k]          = (b == n - 1);
  endtask

  task automatic push(input int k, input int b, input int n, input logic [3:0] last_be);
    exp_q.push_back({(b == n - 1), ((b == n - 1) ? last_be : 4'hF), pat(k, b)});
  endtask

  // Owner k streams an n-beat frame, advancing only when its ready is seen
  task automatic drive_frame(input int k, input int n, input logic [3:0] last_be);
    for (int b = 0; b < n; b++) begin
      int g;
      bit acc;
      g = 0;
      acc = 1'b0;
      present(k, b, n, last_be);
      push(k, b, n, last_be);
      while (!acc && g < 64) begin
        @(negedge clk);
        acc = data_ready_o[k] && mac_wld_o;
        tick();
        g++;
      end
      if (!acc) check("beat_accept_timeout", 64'(acc), 64'd1);
    end
    wld[k]   = 1'b0;
    tlast[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int beats0;

    // Reset state
    #1;
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_abort", 64'(abort_o), 64'd0);
    check("rst_wld", 64'(mac_wld_o), 64'd0);
    check("rst_tlast", 64'(mac_tlast_o), 64'd0);
    check("rst_ready", 64'(data_ready_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(ST_IDLE));
    tick();
    rst = 1'b0;

    // 1: 14-beat ARP frame
    req = 3'b001;
    @(negedge clk);
    check("t1_gnt_pre", 64'(gnt_o), 64'd0);
    tick();
    check("t1_gnt", 64'(gnt_o), 64'b001);
    check("t1_state", 64'(state_o), 64'(ST_XFER));
    req = 3'b000;
    beats0 = n_beats;
    drive_frame(0, 14, 4'b0011);
    check("t1_gnt_release", 64'(gnt_o), 64'd0);
    check("t1_wld_after", 64'(mac_wld_o), 64'd0);
    check("t1_beats", 64'(n_beats - beats0), 64'd14);

    // 2: all requesting, 2-beat frames, order ARP IP ICMP ARP
    do_reset();
    req = 3'b111;
    tick();
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      check("t2_gnt_order", 64'(gnt_o), 64'(3'b001 << (f % 3)));
      tick();
      drive_frame(f % 3, 2, 4'hF);
      if (f == 3) req = 3'b000;
      @(negedge clk);
      check("t2_idle_gap", 64'(gnt_o), 64'd0);
      tick();
    end

    // 3: IP granted with ready 1,0,0,1 while ICMP drives a beat it must not leak
    req = 3'b110;
    present(2, 5, 6, 4'hF);
    tick();
    check("t3_gnt", 64'(gnt_o), 64'b010);
    req = 3'b100;
    present(1, 0, 2, 4'hF);
    push(1, 0, 2, 4'hF);
    mac_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_c1", 64'(data_ready_o), 64'b010);
    check("t3_data_c1", 64'(mac_data_o), 64'(pat(1, 0)));
    tick();
    present(1, 1, 2, 4'hF);
    push(1, 1, 2, 4'hF);
    mac_ready = 1'b0;
    @(negedge clk);
    check("t3_ready_c2", 64'(data_ready_o), 64'b000);
    check("t3_data_c2", 64'(mac_data_o), 64'(pat(1, 1)));
    check("t3_tlast_c2", 64'(mac_tlast_o), 64'd1);
    tick();
    @(negedge clk);
    check("t3_hold_gnt", 64'(gnt_o), 64'b010);
    check("t3_hold_data", 64'(mac_data_o), 64'(pat(1, 1)));
    tick();
    mac_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_c4", 64'(data_ready_o), 64'b010);
    tick();
    wld = '0;
    tlast = '0;

    // 4: ICMP granted but never sends; ARP pending
    req = 3'b101;
    @(negedge clk);
    check("t3_release", 64'(gnt_o), 64'd0);
    tick();
    check("t4_gnt_icmp", 64'(gnt_o), 64'b100);
    req = 3'b001;
    @(negedge clk);
    c = 0;
    while (!abort_o && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("t4_abort_latency", 64'(c), 64'd16);
    check("t4_abort_gnt", 64'(gnt_o), 64'd0);
    @(negedge clk);
    check("t4_abort_pulse", 64'(abort_o), 64'd0);
    check("t4_arp_next", 64'(gnt_o), 64'b001);
    req = 3'b000;
    tick();
    drive_frame(0, 1, 4'h1);

    // 5: reset on beat 3 of a 10-beat IP frame
    do_reset();
    req = 3'b010;
    tick();
    check("t5_gnt", 64'(gnt_o), 64'b010);
    req = 3'b000;
    for (int b = 0; b < 2; b++) begin
      present(1, b, 10, 4'hF);
      push(1, b, 10, 4'hF);
      tick();
    end
    present(1, 2, 10, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_gnt", 64'(gnt_o), 64'd0);
    check("t5_rst_wld", 64'(mac_wld_o), 64'd0);
    check("t5_rst_ready", 64'(data_ready_o), 64'd0);
    tick();
    wld = '0;
    tlast = '0;
    rst = 1'b0;
    req = 3'b011;
    tick();
    check("t5_arp_wins", 64'(gnt_o), 64'b001);

    // 6: single-beat ARP frame then IP
    present(0, 0, 1, 4'h7);
    push(0, 0, 1, 4'h7);
    req = 3'b010;
    beats0 = n_beats;
    tick();
    wld = '0;
    tlast = '0;
    check("t6_idle", 64'(gnt_o), 64'd0);
    check("t6_one_beat", 64'(n_beats - beats0), 64'd1);
    tick();
    check("t6_ip_gnt", 64'(gnt_o), 64'b010);
    req = 3'b000;
    drive_frame(1, 1, 4'hF);
    check("t6_ip_release", 64'(gnt_o), 64'd0);

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
